// File: rtl/prog_sequencer_pkg.sv
// Shared types and constants for the program sequencer slice.
//   state_t        sequencer FSM states
//   NUM_PROGS_DEF  default number of stored programs
//   PC_W           width of the program counter value
//   PROG_IDX_W     width of the program index
package prog_seq_pkg;

   localparam int NUM_PROGS_DEF = 3;
   localparam int PC_W          = 10;
   localparam int PROG_IDX_W    = 2;

   typedef enum logic [2:0] {
      IDLE,
      INIT,
      RUN,
      DONE,
      FINISHED
   } state_t;

endpackage

// File: rtl/prog_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear.
//   CLK    clock
//   Reset  synchronous active-high reset, count -> 0
//   Clr    synchronous clear, wins over En
//   En     increment enable; the count sticks at all-ones
//   Count  current count
module sat_counter #(
   parameter int W = 8
) (
   input  logic         CLK,
   input  logic         Reset,
   input  logic         Clr,
   input  logic         En,
   output logic [W-1:0] Count
);

   // NOTE: sequential state is assigned with <= so every flop samples
   // the pre-edge values of its inputs, independent of statement order.
   always_ff @(posedge CLK) begin
      if (Reset || Clr) begin
         Count <= '0;
      end else if (En && (Count != '1)) begin
         Count <= Count + W'(1);
      end
   end

endmodule

// File: rtl/prog_sequencer.sv
// Upstream control stage for the program counter. Starts each stored program
// on request by pulsing Init, waits for Halt, records the run length and the
// PC where it stopped, and reports completion over a level Req/Ack handshake.
//   CLK         clock
//   Reset       synchronous active-high reset, wins over all other inputs
//   Req         level request to start the next program
//   Halt        halt flag from the PC stage
//   PcValue     current PC from the PC stage
//   Init        init pulse to the PC stage
//   Busy        high while initialising or running
//   Ack         level: current program finished
//   Err         with Ack: run ended by timeout rather than Halt
//   ProgIdx     index of program being run / last run
//   CycleCount  run cycles of the last program, Halt cycle excluded
//   HaltPc      PcValue captured when the run ended
//   AllDone     every program has been acknowledged
module prog_sequencer
   import prog_seq_pkg::*;
#(
   parameter int NUM_PROGS   = NUM_PROGS_DEF,
   parameter int INIT_CYCLES = 2,
   parameter int CNT_W       = 16,
   parameter int TIMEOUT     = 65000
) (
   input  logic                  CLK,
   input  logic                  Reset,
   input  logic                  Req,
   input  logic                  Halt,
   input  logic [PC_W-1:0]       PcValue,
   output logic                  Init,
   output logic                  Busy,
   output logic                  Ack,
   output logic                  Err,
   output logic [PROG_IDX_W-1:0] ProgIdx,
   output logic [CNT_W-1:0]      CycleCount,
   output logic [PC_W-1:0]       HaltPc,
   output logic                  AllDone
);

   localparam int                  INIT_W   = $clog2(INIT_CYCLES) + 1;
   localparam logic [PROG_IDX_W-1:0] LAST_IDX = PROG_IDX_W'(NUM_PROGS - 1);

   state_t            state;
   state_t            state_nxt;
   logic              armed;
   logic [INIT_W-1:0] init_cnt;
   logic [CNT_W-1:0]  run_cnt;
   logic              init_last;
   logic              run_timeout;
   logic              start;

   // Both counters sit at zero outside their own state, so each phase
   // begins with a cleared count.
   sat_counter #(.W(INIT_W)) u_init_cnt (
      .CLK   (CLK),
      .Reset (Reset),
      .Clr   (state != INIT),
      .En    (state == INIT),
      .Count (init_cnt)
   );

   sat_counter #(.W(CNT_W)) u_run_cnt (
      .CLK   (CLK),
      .Reset (Reset),
      .Clr   (state != RUN),
      .En    ((state == RUN) && !Halt),
      .Count (run_cnt)
   );

   assign init_last   = (init_cnt == INIT_W'(INIT_CYCLES - 1));
   assign run_timeout = (run_cnt == CNT_W'(TIMEOUT - 1));
   assign start       = Req && armed;

   always_ff @(posedge CLK) begin
      if (Reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // NOTE: state_nxt gets its default before the case, so every path
   // assigns it and no latch is inferred.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:     if (start)                state_nxt = INIT;
         INIT:     if (init_last)            state_nxt = RUN;
         RUN:      if (Halt || run_timeout)  state_nxt = DONE;
         DONE:     if (!Req)                 state_nxt = (ProgIdx == LAST_IDX) ? FINISHED : IDLE;
         FINISHED:                           state_nxt = FINISHED;
         default:                            state_nxt = IDLE;
      endcase
   end

   // A start consumes the arm; it is re-armed only once Req is seen low,
   // so a request held high never launches a second program. Reset leaves
   // it armed so a request present at reset release starts immediately.
   always_ff @(posedge CLK) begin
      if (Reset) begin
         armed <= 1'b1;
      end else if ((state == IDLE) && start) begin
         armed <= 1'b0;
      end else if (!Req) begin
         armed <= 1'b1;
      end
   end

   // Result registers: written only when RUN exits, held otherwise.
   // Halt has priority over a timeout landing on the same edge.
   always_ff @(posedge CLK) begin
      if (Reset) begin
         Err        <= 1'b0;
         CycleCount <= '0;
         HaltPc     <= '0;
         ProgIdx    <= '0;
      end else begin
         if (state == RUN) begin
            if (Halt) begin
               Err        <= 1'b0;
               CycleCount <= run_cnt;
               HaltPc     <= PcValue;
            end else if (run_timeout) begin
               Err        <= 1'b1;
               CycleCount <= CNT_W'(TIMEOUT);
               HaltPc     <= PcValue;
            end
         end
         if ((state == DONE) && !Req && (ProgIdx != LAST_IDX)) begin
            ProgIdx <= ProgIdx + PROG_IDX_W'(1);
         end
      end
   end

   assign Init    = (state == INIT);
   assign Busy    = (state == INIT) || (state == RUN);
   assign Ack     = (state == DONE);
   assign AllDone = (state == FINISHED);

endmodule
